// File: rtl/pulse_field_if.sv
// Pulse field monitor bus: field inputs, score clear,
// and the display / rally / collision outputs.
interface pulse_field_if #(
  parameter int WIDTH = 18
);
  logic             tick;
  logic [WIDTH-1:0] left_field;
  logic [WIDTH-1:0] right_field;
  logic             clear;
  logic [6:0]       HEX0;
  logic [6:0]       HEX1;
  logic [6:0]       HEX2;
  logic [6:0]       HEX3;
  logic [6:0]       HEX4;
  logic [6:0]       HEX5;
  logic [6:0]       HEX6;
  logic [6:0]       HEX7;
  logic [13:0]      collisions;
  logic             rally_live;
  logic             rally_done;

  modport master (
    output tick, left_field, right_field, clear,
    input  HEX0, HEX1, HEX2, HEX3,
    input  HEX4, HEX5, HEX6, HEX7,
    input  collisions, rally_live, rally_done
  );

  modport slave (
    input  tick, left_field, right_field, clear,
    output HEX0, HEX1, HEX2, HEX3,
    output HEX4, HEX5, HEX6, HEX7,
    output collisions, rally_live, rally_done
  );
endinterface

// File: rtl/pulse_field_monitor.sv
// LED pulse field scoreboard: capture, decode, score, display.
// Collision counting is built only with PULSE_MONITOR_COLLISION_EN.
module pulse_field_monitor #(
  parameter int WIDTH      = 18,
  parameter int HOLD_TICKS = 4
) (
  input logic         CLOCK_50,
  input logic         reset,
  pulse_field_if.slave bus
);

  typedef struct packed {
    logic [WIDTH-1:0] l;
    logic [WIDTH-1:0] r;
  } cap_t;

  typedef struct packed {
    logic ev_low;
    logic ev_high;
    logic any;
  } dec_t;

  typedef enum logic [1:0] {
    IDLE,
    LIVE,
    DRAIN
  } st_t;

  localparam logic [3:0] HOLD = 4'(HOLD_TICKS);

  logic        v1, v2;
  cap_t        s1;
  dec_t        d_n, s2;
  logic [15:0] lo_q, hi_q;
  st_t         st_q, st_n;
  logic [3:0]  cnt_q, cnt_n;
  logic        done_q, done_n;
  logic [6:0]  hex_q [8];

  function automatic logic [15:0] bcd_inc(
    input logic [15:0] v
  );
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    if (v == 16'h9999) return v;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(
    input logic [3:0] d
  );
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      v1 <= 1'b0;
      s1 <= '0;
    end else begin
      v1 <= bus.tick & ~bus.clear;
      if (bus.tick) begin
        s1.l <= bus.left_field;
        s1.r <= bus.right_field;
      end
    end
  end

  always_comb begin
    d_n.ev_low  = s1.l[0] & ~s1.r[0];
    d_n.ev_high = s1.r[WIDTH-1] & ~s1.l[WIDTH-1];
    d_n.any     = |(s1.l | s1.r);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      v2 <= 1'b0;
      s2 <= '0;
    end else begin
      v2 <= v1 & ~bus.clear;
      if (v1) s2 <= d_n;
    end
  end

`ifdef PULSE_MONITOR_COLLISION_EN
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] cmask;
  logic [CW-1:0]    ncol_n, ncol_q;
  logic [13:0]      col_q;
  logic [14:0]      col_sum;

  // A left pulse one cell above a right pulse crosses it this tick
  always_comb begin
    cmask  = (s1.l & s1.r) | ((s1.l >> 1) & s1.r);
    ncol_n = '0;
    for (int i = 0; i < WIDTH; i++)
      ncol_n = ncol_n + CW'(cmask[i]);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) ncol_q <= '0;
    else if (v1) ncol_q <= ncol_n;
  end

  assign col_sum = {1'b0, col_q} + 15'(ncol_q);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      col_q <= '0;
    end else if (bus.clear) begin
      col_q <= '0;
    end else if (v2) begin
      col_q <= col_sum[14] ? 14'h3fff : col_sum[13:0];
    end
  end

  assign bus.collisions = col_q;
`else
  assign bus.collisions = '0;
`endif

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      lo_q <= '0;
      hi_q <= '0;
    end else if (bus.clear) begin
      lo_q <= '0;
      hi_q <= '0;
    end else if (v2) begin
      if (s2.ev_low)  lo_q <= bcd_inc(lo_q);
      if (s2.ev_high) hi_q <= bcd_inc(hi_q);
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_n;
      cnt_q  <= cnt_n;
      done_q <= done_n;
    end
  end

  // cnt_q holds the number of empty ticks seen since LIVE
  always_comb begin
    st_n   = st_q;
    cnt_n  = cnt_q;
    done_n = 1'b0;
    if (bus.clear) begin
      st_n  = IDLE;
      cnt_n = '0;
    end else if (v2) begin
      unique case (1'b1)
        (st_q == IDLE): begin
          if (s2.any) st_n = LIVE;
        end
        (st_q == LIVE): begin
          if (!s2.any) begin
            if (HOLD == 4'd1) begin
              st_n   = IDLE;
              done_n = 1'b1;
            end else begin
              st_n  = DRAIN;
              cnt_n = 4'd1;
            end
          end
        end
        (st_q == DRAIN): begin
          if (s2.any) begin
            st_n = LIVE;
          end else if (cnt_q + 4'd1 == HOLD) begin
            st_n   = IDLE;
            cnt_n  = '0;
            done_n = 1'b1;
          end else begin
            cnt_n = cnt_q + 4'd1;
          end
        end
        default: begin
          st_n  = IDLE;
          cnt_n = '0;
        end
      endcase
    end
  end

  assign bus.rally_live = (st_q != IDLE);
  assign bus.rally_done = done_q;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++)
        hex_q[i] <= 7'b1000000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        hex_q[i]   <= seg7(lo_q[i*4 +: 4]);
        hex_q[i+4] <= seg7(hi_q[i*4 +: 4]);
      end
    end
  end

  assign bus.HEX0 = hex_q[0];
  assign bus.HEX1 = hex_q[1];
  assign bus.HEX2 = hex_q[2];
  assign bus.HEX3 = hex_q[3];
  assign bus.HEX4 = hex_q[4];
  assign bus.HEX5 = hex_q[5];
  assign bus.HEX6 = hex_q[6];
  assign bus.HEX7 = hex_q[7];

endmodule

// File: tb/tb_pulse_field_monitor.sv
// Bench for pulse_field_monitor: directed vectors against
// an event-queue model of scores, collisions and rallies.
module tb_pulse_field_monitor;

  localparam int W    = 18;
  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #10 clk = ~clk;

  pulse_field_if #(.WIDTH(W)) bus ();

  pulse_field_monitor #(
    .WIDTH(W),
    .HOLD_TICKS(HOLD)
  ) dut (
    .CLOCK_50(clk),
    .reset(rst),
    .bus(bus)
  );

  typedef struct {
    int           due;
    logic [W-1:0] l;
    logic [W-1:0] r;
  } ev_t;

  ev_t q[$];
  ev_t e;

  int vectors     = 0;
  int miscompares = 0;

  int m_lo, m_hi, m_col;
  int h_lo, h_hi;
  int m_empty;
  int m_done_cnt;
  int cyc;
  int n;
  bit m_live, m_done;
  int base;

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Pulses meet if they share a cell or a left pulse sits
  // just above a right pulse (they swap cells this tick).
  function automatic int meets(
    input logic [W-1:0] l,
    input logic [W-1:0] r
  );
    int k;
    k = 0;
    for (int i = 0; i < W; i++) begin
      if (l[i] && r[i]) k++;
      else if (i + 1 < W && l[i+1] && r[i]) k++;
    end
    return k;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  initial begin
    m_lo = 0; m_hi = 0; m_col = 0;
    h_lo = 0; h_hi = 0;
    m_empty = 0; m_done_cnt = 0;
    cyc = 0; m_live = 0; m_done = 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_lo = 0; m_hi = 0; m_col = 0;
      h_lo = 0; h_hi = 0;
      m_live = 0; m_empty = 0; m_done = 0;
    end else begin
      h_lo   = m_lo;
      h_hi   = m_hi;
      m_done = 0;
      if (bus.clear) begin
        q.delete();
        m_lo = 0; m_hi = 0; m_col = 0;
        m_live = 0; m_empty = 0;
      end else begin
        while (q.size() > 0 && q[0].due == cyc) begin
          e = q.pop_front();
          if (e.l[0] && !e.r[0] && m_lo < 9999) m_lo++;
          if (e.r[W-1] && !e.l[W-1] && m_hi < 9999) m_hi++;
`ifdef PULSE_MONITOR_COLLISION_EN
          n = meets(e.l, e.r);
          m_col = (m_col + n > 16383) ? 16383 : m_col + n;
`endif
          if ((e.l | e.r) != '0) begin
            m_live  = 1;
            m_empty = 0;
          end else if (m_live) begin
            m_empty++;
            if (m_empty == HOLD) begin
              m_live  = 0;
              m_empty = 0;
              m_done  = 1;
              m_done_cnt++;
            end
          end
        end
        if (bus.tick)
          q.push_back('{due: cyc + 2,
                        l: bus.left_field,
                        r: bus.right_field});
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("HEX0", int'(bus.HEX0), int'(seg(h_lo % 10)));
      chk("HEX1", int'(bus.HEX1), int'(seg(h_lo / 10 % 10)));
      chk("HEX2", int'(bus.HEX2), int'(seg(h_lo / 100 % 10)));
      chk("HEX3", int'(bus.HEX3), int'(seg(h_lo / 1000)));
      chk("HEX4", int'(bus.HEX4), int'(seg(h_hi % 10)));
      chk("HEX5", int'(bus.HEX5), int'(seg(h_hi / 10 % 10)));
      chk("HEX6", int'(bus.HEX6), int'(seg(h_hi / 100 % 10)));
      chk("HEX7", int'(bus.HEX7), int'(seg(h_hi / 1000)));
      chk("collisions", int'(bus.collisions), m_col);
      chk("rally_live", int'(bus.rally_live), int'(m_live));
      chk("rally_done", int'(bus.rally_done), int'(m_done));
    end
  end

  task automatic step(
    input logic         t,
    input logic [W-1:0] l,
    input logic [W-1:0] r,
    input logic         c
  );
    bus.tick        = t;
    bus.left_field  = l;
    bus.right_field = r;
    bus.clear       = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    bus.tick        = 1'b0;
    bus.left_field  = '0;
    bus.right_field = '0;
    bus.clear       = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(2);
    chk("lit_reset_hex0", int'(bus.HEX0), 7'b1000000);
    chk("lit_reset_hex7", int'(bus.HEX7), 7'b1000000);
    chk("lit_reset_col", int'(bus.collisions), 0);
    chk("lit_reset_live", int'(bus.rally_live), 0);

    // single left exit
    step(1'b1, 18'h00001, 18'h00000, 1'b0);
    idle(2);
    chk("lit_lo_one", m_lo, 1);
    chk("lit_live_t2", int'(bus.rally_live), 1);
    idle(1);
    chk("lit_hex0_one", int'(bus.HEX0), 7'b1111001);
    chk("lit_hex1_zero", int'(bus.HEX1), 7'b1000000);

    // empty ticks end the rally on the fourth
    base = m_done_cnt;
    for (int i = 0; i < 3; i++) step(1'b1, '0, '0, 1'b0);
    idle(2);
    chk("lit_live_3empty", int'(bus.rally_live), 1);
    step(1'b1, '0, '0, 1'b0);
    idle(2);
    chk("lit_done_pulse", int'(bus.rally_done), 1);
    idle(1);
    chk("lit_done_once", int'(bus.rally_done), 0);
    chk("lit_live_off", int'(bus.rally_live), 0);
    chk("lit_model_done", m_done_cnt - base, 1);

    // crossing plus same-cell meeting
    step(1'b1, 18'h00002, 18'h00001, 1'b0);
    step(1'b1, 18'h00100, 18'h00100, 1'b0);
    idle(3);
`ifdef PULSE_MONITOR_COLLISION_EN
    chk("lit_col_two", int'(bus.collisions), 2);
`else
    chk("lit_col_zero", int'(bus.collisions), 0);
`endif
    chk("lit_no_exit_lo", m_lo, 1);
    chk("lit_no_exit_hi", m_hi, 0);

    // clear racing a tick
    base = m_done_cnt;
    step(1'b1, 18'h00001, 18'h00000, 1'b1);
    idle(3);
    chk("lit_clr_lo", m_lo, 0);
    chk("lit_clr_hex0", int'(bus.HEX0), 7'b1000000);
    chk("lit_clr_live", int'(bus.rally_live), 0);
    chk("lit_clr_nodone", m_done_cnt - base, 0);
    chk("lit_clr_col", int'(bus.collisions), 0);

    // reset with an event in flight
    step(1'b1, 18'h00001, 18'h00000, 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(3);
    chk("lit_rst_lo", m_lo, 0);
    chk("lit_rst_hex0", int'(bus.HEX0), 7'b1000000);
    chk("lit_rst_live", int'(bus.rally_live), 0);

    // left exit with a same-cell meet at the top edge
    step(1'b1, 18'h20001, 18'h20000, 1'b0);
    idle(3);
    chk("lit_edge_lo", m_lo, 1);
    chk("lit_edge_hi", m_hi, 0);

    // drive the high score into saturation
    for (int i = 0; i < 10000; i++)
      step(1'b1, 18'h00000, 18'h20000, 1'b0);
    idle(3);
    chk("lit_sat_hi", m_hi, 9999);
    chk("lit_sat_hex4", int'(bus.HEX4), 7'b0010000);
    chk("lit_sat_hex5", int'(bus.HEX5), 7'b0010000);
    chk("lit_sat_hex6", int'(bus.HEX6), 7'b0010000);
    chk("lit_sat_hex7", int'(bus.HEX7), 7'b0010000);
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pulse_field_monitor.md
# pulse_field_monitor

Scoreboard/reader for the LED pulse field. Samples the two pulse vectors (left-injected, travelling toward bit 0; right-injected, travelling toward bit WIDTH-1) once per field-update tick. Decodes edge exits, collisions and rally activity, and keeps saturating scores. Drives the eight seven-segment displays alongside the pulse field on LEDR.

## Interface
- WIDTH, 18, pulse field width (one bit per LEDR lamp)
- HOLD_TICKS, 4, empty-field ticks before a rally is declared over (1..15)
- CLOCK_50  in  1  system clock, all logic on posedge
- reset  in  1  asynchronous, active-high reset
- tick  in  1  one-cycle strobe, asserted the cycle the field generator updates its vectors
- left_field  in  WIDTH  left-injected pulses, valid when tick=1
- right_field  in  WIDTH  right-injected pulses, valid when tick=1
- clear  in  1  synchronous score clear, already synchronised
- HEX0..HEX7  out  7 each  active-low segments {g,f,e,d,c,b,a}
- collisions  out  14  binary collision total, saturating
- rally_live  out  1  high while a rally is in progress
- rally_done  out  1  one-cycle pulse when a rally ends

## Operation
- Stage 1 (capture): on tick, register L=left_field and R=right_field; set v1. Non-tick cycles: v1=0, L/R hold.
- Stage 2 (decode, when v1):
  - exit_low = L[0] & ~R[0]: a left pulse leaves at bit 0.
  - exit_high = R[WIDTH-1] & ~L[WIDTH-1].
  - Collision mask C = (L & R) | ((L >> 1) & R). ncol = popcount(C), 0..WIDTH. Register as ev_low, ev_high, ncol, any=(L|R)!=0; set v2.
- Stage 3 (update, when v2):
  - Low score: 4-digit BCD, +1 on ev_low. Digits carry 9→0. Saturates at 9999; no wrap.
  - High score: the same, on ev_high.
  - collisions += ncol, clamped to 16383.
- Rally FSM (advances only when v2):
  - IDLE → LIVE when any=1.
  - LIVE → DRAIN when any=0; idle-tick counter loads 1.
  - DRAIN → LIVE when any=1.
  - DRAIN: when any=0, count+1. When count reaches HOLD_TICKS → IDLE, pulse rally_done.
  - rally_live=1 in LIVE and DRAIN.
- Display, registered from the score registers:
  - HEX3..HEX0 = low score, thousands to units.
  - HEX7..HEX4 = high score, thousands to units.
  - Digits 0-9 standard; no leading-zero blanking.
- clear: zeroes both scores and collisions, forces FSM to IDLE, and kills v1/v2 in the same cycle. clear wins over a simultaneous tick or update.

## Timing
- Reset values:
  - Scores=0, collisions=0, FSM=IDLE, v1=v2=0.
  - rally_live=0, rally_done=0.
  - HEX0..HEX7=7'b1000000 (digit 0).
- Latency: tick at cycle t → decode at t+1 → scores/collisions/FSM updated at the t+2 edge → HEX reflects at t+3.
- rally_done is high for exactly the one cycle after the t+2 edge.
- Back-to-back ticks (every cycle) are sustained at full throughput; no stall, no ready.
- A tick arriving while v1/v2 are in flight does not corrupt earlier events.
- Reset mid-pipeline discards in-flight events; there are no partial updates.
- WIDTH=1: the collision mask reduces to L&R, and exit_low/exit_high share bit 0.

## Configuration
- PULSE_MONITOR_COLLISION_EN defined: popcount, collision accumulator and collisions output are present as above.
- Undefined: no popcount or accumulator is synthesised; collisions is tied to 0. Exits, FSM and HEX are unchanged.

## Test plan
- Reset, then idle: all HEX=7'b1000000, collisions=0, rally_live=0.
- Tick with L=18'h00001, R=0: at t+2 the low score is 1 and rally_live=1; HEX0=7'b1111001 at t+3. Then ticks with L=R=0: rally_done pulses on the 4th empty tick; rally_live returns to 0.
- Tick with L=18'h00002, R=18'h00001 (crossing) plus L=R=18'h00100 (same cell): collisions +=2 (macro defined), or stays 0 (undefined). No exit counted.
- Preload the high score to 9999 via 9999 ticks with R=18'h20000, L=0, plus one more: the score stays 9999 and HEX7..HEX4 all show 9 (7'b0010000).
- clear asserted in the same cycle as a tick with L=18'h00001: the low score stays 0, FSM=IDLE, and no rally_done pulse.
- Assert reset between tick and t+2 with L=18'h00001: after release the low score is 0 and HEX0 shows 0.
